// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the add/subtract operation encoding.
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_N   = 256;
    localparam int COEFF_WID = 12;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_t;

endpackage

// File: rtl/mod_addsub_lane.sv
// One coefficient lane: stage-1 sum/difference and stage-2 conditional
// subtraction, both purely combinational; the pipeline registers live in the top.
module mod_addsub_lane
    import kyber_pkg::*;
#(
    parameter int DATA_WID = COEFF_WID,
    parameter int Q        = KYBER_Q
) (
    input  logic [DATA_WID-1:0] a,
    input  logic [DATA_WID-1:0] b,
    input  op_mode_t            mode,
    input  logic [DATA_WID:0]   s_in,
    output logic [DATA_WID:0]   s_out,
    output logic [DATA_WID-1:0] c_out,
    output logic                out_of_range
);

    localparam logic [DATA_WID:0] Q_EXT = (DATA_WID + 1)'(Q);

    logic [DATA_WID:0] a_ext;
    logic [DATA_WID:0] b_ext;
    logic [DATA_WID:0] c_full;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Adding Q before the difference keeps the subtract result non-negative,
    // so both modes share the same single conditional-subtract reduction.
    always_comb begin
        if (mode == OP_SUB) begin
            s_out = a_ext - b_ext + Q_EXT;
        end else begin
            s_out = a_ext + b_ext;
        end
    end

    always_comb begin
        if (s_in >= Q_EXT) begin
            c_full = s_in - Q_EXT;
        end else begin
            c_full = s_in;
        end
    end

    assign c_out        = c_full[DATA_WID-1:0];
    assign out_of_range = (a_ext >= Q_EXT) || (b_ext >= Q_EXT);

endmodule

// File: rtl/poly_mod_addsub.sv
// Two-stage streaming modular add/subtract of polynomials, LANES coefficients
// per beat, with whole-pipeline stall, per-polynomial mode latch and last tagging.
module poly_mod_addsub
    import kyber_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int DATA_WID = COEFF_WID,
    parameter int Q        = KYBER_Q,
    parameter int N        = KYBER_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_WID-1:0] in_a,
    input  logic [LANES*DATA_WID-1:0] in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_WID-1:0] out_c,
    output logic                      out_last,
    output logic                      range_err
);

    localparam int BEATS = N / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int S_WID = DATA_WID + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [LANES*S_WID-1:0]    s1_d, s1_q;
    logic                      v1_d, v1_q;
    logic                      last1_d, last1_q;
    logic [LANES*DATA_WID-1:0] c_d, c_q;
    logic                      v2_d, v2_q;
    logic                      last2_d, last2_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;
    op_mode_t                  mode_d, mode_q;
    logic                      range_err_d, range_err_q;

    logic                      advance;
    logic                      accept;
    op_mode_t                  beat_mode;
    logic [LANES*S_WID-1:0]    s_lane;
    logic [LANES*DATA_WID-1:0] c_lane;
    logic [LANES-1:0]          lane_oor;

    // The whole pipeline moves together; it only freezes when the output
    // register holds a beat the consumer has not taken.
    assign advance   = !(v2_q && !out_ready);
    assign accept    = in_valid && advance;
    assign beat_mode = (cnt_q == '0) ? op_mode_t'(mode) : mode_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            mod_addsub_lane #(
                .DATA_WID (DATA_WID),
                .Q        (Q)
            ) u_lane (
                .a            (in_a[gi*DATA_WID +: DATA_WID]),
                .b            (in_b[gi*DATA_WID +: DATA_WID]),
                .mode         (beat_mode),
                .s_in         (s1_q[gi*S_WID +: S_WID]),
                .s_out        (s_lane[gi*S_WID +: S_WID]),
                .c_out        (c_lane[gi*DATA_WID +: DATA_WID]),
                .out_of_range (lane_oor[gi])
            );
        end
    endgenerate

    always_comb begin
        s1_d    = s1_q;
        v1_d    = v1_q;
        last1_d = last1_q;
        c_d     = c_q;
        v2_d    = v2_q;
        last2_d = last2_q;
        if (advance) begin
            s1_d    = s_lane;
            v1_d    = in_valid;
            last1_d = in_valid && (cnt_q == LAST_BEAT);
            c_d     = c_lane;
            v2_d    = v1_q;
            last2_d = last1_q;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        range_err_d = range_err_q;
        if (accept) begin
            cnt_d       = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
            mode_d      = beat_mode;
            range_err_d = range_err_q || (|lane_oor);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            c_q         <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= OP_ADD;
            range_err_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            v1_q        <= v1_d;
            last1_q     <= last1_d;
            c_q         <= c_d;
            v2_q        <= v2_d;
            last2_q     <= last2_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            range_err_q <= range_err_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = v2_q;
    assign out_c     = c_q;
    assign out_last  = last2_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_poly_mod_addsub.sv
// Directed vector table plus scoreboarded streaming, stall, reset and mode-latch sequences.
module tb_poly_mod_addsub;

    localparam int LANES = 4;
    localparam int DW    = 12;
    localparam int QV    = 3329;
    localparam int NV    = 256;
    localparam int BEATS = NV / LANES;
    localparam int W     = LANES * DW;

    logic         clk;
    logic         rst;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_c;
    logic         out_last;
    logic         range_err;

    poly_mod_addsub #(
        .LANES    (LANES),
        .DATA_WID (DW),
        .Q        (QV),
        .N        (NV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_last  (out_last),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input logic ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_op(input int a, input int b, input logic sub);
        int r;
        if (sub) r = (a - b + QV) % QV;
        else     r = (a + b) % QV;
        return 12'(r);
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 12'($urandom_range(0, QV - 1));
        return v;
    endfunction

    // Scoreboard state, sampled on the falling edge
    typedef struct packed {
        logic [W-1:0] c;
        logic         last;
        logic         dc;
    } exp_t;

    exp_t         exp_q[$];
    int           m_cnt = 0;
    logic         m_mode = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_c = '0;
    logic         prev_last = 1'b0;
    int           out_beats = 0;
    int           n_last = 0;
    int           last_idx[4];
    int           cyc = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;
    int           stall_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        logic cur_mode;
        logic oor;
        int   ai;
        int   bi;
        cyc <= cyc + 1;
        if (rst) begin
            exp_q.delete();
            m_cnt      <= 0;
            m_mode     <= 1'b0;
            prev_stall <= 1'b0;
            out_beats  <= 0;
            n_last     <= 0;
        end else begin
            if (in_valid && in_ready) begin
                cur_mode = (m_cnt == 0) ? mode : m_mode;
                oor = 1'b0;
                e.c = '0;
                for (int i = 0; i < LANES; i++) begin
                    ai = int'(in_a[i*DW +: DW]);
                    bi = int'(in_b[i*DW +: DW]);
                    if (ai >= QV || bi >= QV) oor = 1'b1;
                    e.c[i*DW +: DW] = ref_op(ai, bi, cur_mode);
                end
                e.last = (m_cnt == BEATS - 1);
                e.dc   = oor;
                exp_q.push_back(e);
                m_mode <= cur_mode;
                m_cnt  <= (m_cnt == BEATS - 1) ? 0 : m_cnt + 1;
            end
            if (prev_stall) begin
                check(out_valid == 1'b1, "stall_valid_held", 64'(out_valid), 64'd1);
                check(out_c == prev_c, "stall_c_held", 64'(out_c), 64'(prev_c));
                check(out_last == prev_last, "stall_last_held", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && !out_ready) begin
                check(in_ready == 1'b0, "stall_in_ready", 64'(in_ready), 64'd0);
                stall_seen <= stall_seen + 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "sb_unexpected_beat", 64'(out_c), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.dc) check(out_c == e.c, "sb_c", 64'(out_c), 64'(e.c));
                    check(out_last == e.last, "sb_last", 64'(out_last), 64'(e.last));
                end
                if (out_beats == 0) first_cyc <= cyc;
                last_cyc  <= cyc;
                out_beats <= out_beats + 1;
                if (out_last) begin
                    if (n_last < 4) last_idx[n_last] <= out_beats + 1;
                    n_last <= n_last + 1;
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_c     <= out_c;
            prev_last  <= out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int k;
        in_a = a;
        in_b = b;
        mode = m;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check(1'b0, "accept_timeout", 64'(k), 64'd50);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic          mode;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 12'd10,   12'd20,   12'd30};
        vecs[1]  = '{1'b0, 12'd3328, 12'd3328, 12'd3327};
        vecs[2]  = '{1'b1, 12'd0,    12'd1,    12'd3328};
        vecs[3]  = '{1'b1, 12'd5,    12'd5,    12'd0};
        vecs[4]  = '{1'b0, 12'd3328, 12'd1,    12'd0};
        vecs[5]  = '{1'b0, 12'd1664, 12'd1664, 12'd3328};
        vecs[6]  = '{1'b1, 12'd3328, 12'd0,    12'd3328};
        vecs[7]  = '{1'b1, 12'd0,    12'd3328, 12'd1};
        vecs[8]  = '{1'b0, 12'd0,    12'd0,    12'd0};
        vecs[9]  = '{1'b1, 12'd100,  12'd3000, 12'd429};
        vecs[10] = '{1'b0, 12'd2000, 12'd2000, 12'd671};
        vecs[11] = '{1'b1, 12'd3000, 12'd100,  12'd2900};

        rst = 1'b1;
        mode = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        check(out_c == '0, "rst_out_c", 64'(out_c), 64'd0);
        check(out_last == 1'b0, "rst_out_last", 64'(out_last), 64'd0);
        check(range_err == 1'b0, "rst_range_err", 64'(range_err), 64'd0);
        check(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);

        // Single-beat vectors, each started from reset so the beat is beat 0
        for (int i = 0; i < 12; i++) begin
            pulse_rst();
            in_a = {LANES{vecs[i].a}};
            in_b = {LANES{vecs[i].b}};
            mode = vecs[i].mode;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check(out_valid == 1'b0, "vec_latency_early", 64'(out_valid), 64'd0);
            tick();
            check(out_valid == 1'b1, "vec_latency_valid", 64'(out_valid), 64'd1);
            check(out_c == {LANES{vecs[i].exp}}, "vec_c", 64'(out_c), 64'({LANES{vecs[i].exp}}));
            check(out_last == 1'b0, "vec_last", 64'(out_last), 64'd0);
            tick();
        end

        // Two back-to-back polynomials
        pulse_rst();
        for (int k = 0; k < 2 * BEATS; k++) send_beat(rand_vec(), rand_vec(), (k >= BEATS));
        drain();
        check(out_beats == 2 * BEATS, "stream_beats", 64'(out_beats), 64'(2 * BEATS));
        check(n_last == 2, "stream_last_count", 64'(n_last), 64'd2);
        check(last_idx[0] == BEATS, "stream_last0", 64'(last_idx[0]), 64'(BEATS));
        check(last_idx[1] == 2 * BEATS, "stream_last1", 64'(last_idx[1]), 64'(2 * BEATS));
        check(last_cyc - first_cyc == 2 * BEATS - 1, "stream_no_bubble", 64'(last_cyc - first_cyc), 64'(2 * BEATS - 1));

        // Downstream stall for 5 cycles mid-stream
        pulse_rst();
        stall_seen = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) send_beat(rand_vec(), rand_vec(), 1'b1);
            end
            begin
                repeat (12) tick();
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
            end
        join
        drain();
        check(stall_seen == 5, "stall_cycles", 64'(stall_seen), 64'd5);
        check(out_beats == 40, "stall_beats", 64'(out_beats), 64'd40);

        // Out-of-range input, sticky flag, then reset mid-polynomial
        pulse_rst();
        for (int k = 0; k < 3; k++) send_beat(rand_vec(), rand_vec(), 1'b0);
        check(range_err == 1'b0, "range_err_clean", 64'(range_err), 64'd0);
        begin
            logic [W-1:0] bad;
            bad = rand_vec();
            bad[DW-1:0] = 12'd3329;
            send_beat(bad, rand_vec(), 1'b0);
        end
        check(range_err == 1'b1, "range_err_set", 64'(range_err), 64'd1);
        for (int k = 0; k < 4; k++) send_beat(rand_vec(), rand_vec(), 1'b0);
        check(range_err == 1'b1, "range_err_sticky", 64'(range_err), 64'd1);
        in_a = rand_vec();
        in_b = rand_vec();
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
        check(range_err == 1'b0, "midrst_range_err", 64'(range_err), 64'd0);
        check(in_ready == 1'b1, "midrst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < BEATS; k++) send_beat(rand_vec(), rand_vec(), 1'b0);
        drain();
        check(n_last == 1, "midrst_last_count", 64'(n_last), 64'd1);
        check(last_idx[0] == BEATS, "midrst_last_idx", 64'(last_idx[0]), 64'(BEATS));

        // Mode toggled mid-polynomial only takes effect on the next beat 0
        pulse_rst();
        for (int k = 0; k < BEATS; k++) begin
            if (k == 10) send_beat({LANES{12'd5}}, {LANES{12'd5}}, 1'b1);
            else         send_beat(rand_vec(), rand_vec(), (k >= 10));
        end
        for (int k = 0; k < BEATS; k++) send_beat(rand_vec(), rand_vec(), (k < 5));
        drain();
        check(out_beats == 2 * BEATS, "mode_beats", 64'(out_beats), 64'(2 * BEATS));
        check(range_err == 1'b0, "mode_range_err", 64'(range_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_mod_addsub.md
POLY_MOD_ADDSUB -- requirements
Module: poly_mod_addsub

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  LANES, 4, coefficients processed per beat; legal values 1, 2, 4, 8, 16.
  DATA_WID, 12, coefficient width in bits.
  Q, 3329, modulus.
  N, 256, coefficients per polynomial.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  mode  in  1  0 = add, 1 = subtract (a - b); sampled on the first beat of each polynomial.
  in_valid  in  1  input beat valid.
  in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
  in_a  in  LANES*DATA_WID  packed coefficients of a; lane i at bits [i*DATA_WID +: DATA_WID].
  in_b  in  LANES*DATA_WID  packed coefficients of b.
  out_valid  out  1  result beat valid.
  out_ready  in  1  downstream accepts the result beat.
  out_c  out  LANES*DATA_WID  packed result, every lane in [0, Q-1].
  out_last  out  1  high with the final beat (N/LANES) of a polynomial.
  range_err  out  1  sticky flag: some accepted input coefficient was >= Q.

Function
REQ-003 Each lane SHALL compute (a+b) mod Q in add mode and (a-b) mod Q in subtract mode, for inputs in [0, Q-1].
REQ-004 Stage 1 SHALL register s = a+b (add) or a-b+Q (subtract), DATA_WID+1 bits wide, with no overflow for inputs < Q.
REQ-005 Stage 2 SHALL register c = s-Q when s >= Q, otherwise c = s.
REQ-006 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when no stall occurs.
REQ-007 Throughput SHALL be one beat per cycle while out_ready is high.
REQ-008 Stall: when out_valid=1 and out_ready=0, both stages SHALL hold their contents and in_ready SHALL be 0.
REQ-009 in_ready SHALL equal !(out_valid && !out_ready), and SHALL not depend combinationally on in_valid.
REQ-010 Held outputs (out_c, out_last) SHALL remain stable while out_valid=1 and out_ready=0.
REQ-011 An input beat counter (0 .. N/LANES-1) SHALL increment on each accepted beat and wrap to 0 after the last beat.
REQ-012 mode SHALL be latched when the counter is 0 and a beat is accepted; mode changes mid-polynomial SHALL be ignored until the next polynomial.
REQ-013 out_last SHALL travel through the pipeline with its beat, so it is high only on output beat N/LANES of each polynomial.
REQ-014 Back-to-back polynomials SHALL stream with no bubble; beat 0 of the next polynomial may be accepted in the cycle after the last beat of the previous one.
REQ-015 Any accepted lane with a >= Q or b >= Q SHALL set range_err; range_err SHALL clear only on rst.
REQ-016 For out-of-range inputs, out_c is unspecified but SHALL still be DATA_WID bits wide, and the pipeline SHALL continue normally.
REQ-017 When in_valid=0, the pipeline SHALL insert bubbles; out_valid SHALL go low correspondingly.

Reset
REQ-018 rst SHALL be sampled only on the rising edge of clk.
REQ-019 On reset: out_valid=0, out_c=0, out_last=0, range_err=0, beat counter=0, latched mode=add, all stage-valid bits=0.
REQ-020 in_ready SHALL read 1 in the cycle following reset.
REQ-021 A reset mid-polynomial SHALL discard all in-flight beats; the next accepted beat is treated as beat 0.

Structure
REQ-022 KYBER_Q (3329), KYBER_N (256), COEFF_WID (12) and the enum op_mode_t {OP_ADD, OP_SUB} SHALL live in the shared package kyber_pkg; parameter defaults SHALL reference them.
REQ-023 The per-lane arithmetic SHALL be the sub-module mod_addsub_lane (combinational stage-1 and stage-2 functions), instantiated LANES times via generate; the valid, stall, counter and flag logic SHALL stay in the top module.

Verification
REQ-024 Add mode, lane values a=10, b=20, out_ready=1 -> out_c lane = 30 exactly 2 cycles after acceptance.
REQ-025 Add mode, a=3328, b=3328 -> 3327; subtract mode, a=0, b=1 -> 3328; subtract mode, a=5, b=5 -> 0.
REQ-026 Stream 2 polynomials, 64 beats each (LANES=4) -> out_last high on output beats 64 and 128 only, with no bubbles in between.
REQ-027 Drop out_ready for 5 cycles mid-stream -> in_ready=0 throughout, out_c held stable, no beat lost or duplicated (scoreboard against a reference model).
REQ-028 Accept a beat with a=3329 -> range_err=1 and stays set; assert rst mid-polynomial -> out_valid=0 next cycle, range_err=0, and the following polynomial's out_last falls on its 64th beat.
REQ-029 Toggle mode on beat 10 of a polynomial -> the operation stays as latched on beat 0 until beat 0 of the next polynomial.
